// File: rtl/iwm_multi.sv
// iwm_multi: multi-drive IWM-style disk controller with read latch, motor-off timers and write serializer
module iwm_multi #(
  parameter int NUM_DRIVES = 2,
  parameter int BITCELL_CLKS = 16,
  parameter int LATCH_CLR_CLKS = 14,
  parameter int MOTOR_OFF_CLKS = 8000000
) (
  input  logic                    clk8,
  input  logic                    reset,
  input  logic                    selectIWM,
  input  logic                    _cpuRW,
  input  logic                    _cpuLDS,
  input  logic [3:0]              cpuAddrRegHi,
  input  logic [7:0]              dataIn,
  output logic [7:0]              dataOut,
  input  logic [1:0]              driveBank,
  output logic [2:0]              ca,
  output logic                    lstrb,
  output logic [NUM_DRIVES-1:0]   driveEnable,
  input  logic [NUM_DRIVES-1:0]   rdByteReady,
  input  logic [8*NUM_DRIVES-1:0] rdByte,
  output logic                    wrBit,
  output logic                    wrBitStrobe,
  output logic                    wrActive
);
  localparam int LW = $clog2(LATCH_CLR_CLKS + 1);
  localparam int MW = $clog2(MOTOR_OFF_CLKS + 1);
  localparam int BW = BITCELL_CLKS > 1 ? $clog2(BITCELL_CLKS) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_UNDERRUN = 2'd2;
  logic access, rd, wr, val, q6, q7, q6n, q7n, sel_ext, rd_d, fall;
  logic buf_full, underrun, en_sel, buf_wr, mode_wr;
  logic [2:0] reg_sel, idx;
  logic [7:0] hit, latch, cur_byte, buf_q, sr, en_pad, rdy_pad;
  logic [63:0] rd_pad;
  logic [4:0] mode;
  logic [LW-1:0] clr;
  logic [MW-1:0] mcnt [NUM_DRIVES];
  logic [1:0] state;
  logic [3:0] bits;
  logic [BW-1:0] cc;
  assign access = selectIWM & ~_cpuLDS;
  assign rd = access & _cpuRW;
  assign wr = access & ~_cpuRW;
  assign reg_sel = cpuAddrRegHi[3:1];
  assign val = cpuAddrRegHi[0];
  assign hit = access ? 8'b1 << reg_sel : 8'b0;
  assign q6n = hit[6] ? val : q6;
  assign q7n = hit[7] ? val : q7;
  // masking keeps the drive index in range for 2/4/8 drives
  assign idx = {driveBank, sel_ext} & 3'(NUM_DRIVES - 1);
  assign rd_pad = 64'(rdByte);
  assign cur_byte = rd_pad[{idx, 3'b000} +: 8];
  assign en_pad = 8'(driveEnable);
  assign rdy_pad = 8'(rdByteReady);
  assign en_sel = en_pad[idx];
  assign mode_wr = wr & q7n & q6n & ~|driveEnable;
  assign buf_wr = wr & q7n & q6n & |driveEnable;
  assign fall = rd_d & ~rd;
  assign wrActive = state == S_SHIFT;
  assign dataOut = ~rd ? 8'hFF
                 : q7n ? (q6n ? 8'h00 : {~buf_full, ~underrun, 6'b0})
                 : q6n ? {cur_byte[7], 1'b0, |driveEnable, mode} : latch;
  always_ff @(posedge clk8) begin
    if (reset) begin
      ca <= '0;
      lstrb <= 1'b0;
      sel_ext <= 1'b0;
      q6 <= 1'b0;
      q7 <= 1'b0;
      mode <= '0;
      rd_d <= 1'b0;
    end else begin
      if (hit[0]) ca[0] <= val;
      if (hit[1]) ca[1] <= val;
      if (hit[2]) ca[2] <= val;
      if (hit[3]) lstrb <= val;
      if (hit[5]) sel_ext <= val;
      q6 <= q6n;
      q7 <= q7n;
      rd_d <= rd;
      if (mode_wr) mode <= dataIn[4:0];
    end
  end
  always_ff @(posedge clk8) begin
    if (reset) begin
      driveEnable <= '0;
      for (int i = 0; i < NUM_DRIVES; i++) mcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DRIVES; i++) begin
        if (hit[4] && idx == 3'(i)) begin
          driveEnable[i] <= val | (~mode[2] & driveEnable[i]);
          mcnt[i] <= (val | mode[2]) ? '0 : MW'(MOTOR_OFF_CLKS);
        end else if (mcnt[i] != '0) begin
          mcnt[i] <= mcnt[i] - MW'(1);
          if (mcnt[i] == MW'(1)) driveEnable[i] <= 1'b0;
        end
      end
    end
  end
  // a new byte cancels any pending clear so it survives until it is read
  always_ff @(posedge clk8) begin
    if (reset) begin
      latch <= '0;
      clr <= '0;
    end else begin
      if (rdy_pad[idx]) clr <= '0;
      else if (fall && !mode[0] && latch[7]) clr <= LW'(LATCH_CLR_CLKS);
      else if (clr != '0) clr <= clr - LW'(1);
      if (rdy_pad[idx]) latch <= cur_byte;
      else if (clr == LW'(1)) latch <= '0;
    end
  end
  always_ff @(posedge clk8) begin
    if (reset) begin
      state <= S_IDLE;
      sr <= '0;
      buf_q <= '0;
      buf_full <= 1'b0;
      underrun <= 1'b0;
      bits <= '0;
      cc <= '0;
      wrBit <= 1'b0;
      wrBitStrobe <= 1'b0;
    end else begin
      wrBitStrobe <= 1'b0;
      if (!q7) underrun <= 1'b0;
      if (state != S_IDLE && (!q7 || !en_sel)) state <= S_IDLE;
      else if (state == S_IDLE && q7 && en_sel && buf_full) begin
        state <= S_SHIFT;
        sr <= buf_q;
        buf_full <= 1'b0;
        bits <= 4'd8;
        cc <= BW'(BITCELL_CLKS - 1);
      end else if (state == S_SHIFT) begin
        if (cc != '0) cc <= cc - BW'(1);
        else begin
          wrBit <= sr[7];
          wrBitStrobe <= 1'b1;
          sr <= {sr[6:0], 1'b0};
          bits <= bits - 4'd1;
          cc <= BW'(BITCELL_CLKS - 1);
          if (bits == 4'd1 && buf_full) begin
            sr <= buf_q;
            buf_full <= 1'b0;
            bits <= 4'd8;
          end else if (bits == 4'd1) begin
            state <= S_UNDERRUN;
            underrun <= 1'b1;
          end
        end
      end
      // a CPU write in the same cycle as a reload refills the now-empty buffer
      if (buf_wr) begin
        buf_q <= dataIn;
        buf_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_iwm_multi.sv
// tb_iwm_multi: directed scoreboard bench for iwm_multi with 4 drives and a shortened motor-off timer
module tb_iwm_multi;
  logic clk8, reset, selectIWM, _cpuRW, _cpuLDS, wrBit, wrBitStrobe, wrActive, lstrb;
  logic [3:0] cpuAddrRegHi, driveEnable, rdByteReady;
  logic [7:0] dataIn, dataOut;
  logic [1:0] driveBank;
  logic [2:0] ca;
  logic [31:0] rdByte;
  int passed = 0, total = 0, cyc = 0, strobes = 0, last_strobe = -1, first_strobe = -1, t0, s0;
  logic [7:0] exp_q[$];
  logic exp_bits[$];
  iwm_multi #(.NUM_DRIVES(4), .BITCELL_CLKS(16), .LATCH_CLR_CLKS(14), .MOTOR_OFF_CLKS(50)) dut (
    .clk8(clk8), .reset(reset), .selectIWM(selectIWM), ._cpuRW(_cpuRW), ._cpuLDS(_cpuLDS),
    .cpuAddrRegHi(cpuAddrRegHi), .dataIn(dataIn), .dataOut(dataOut), .driveBank(driveBank),
    .ca(ca), .lstrb(lstrb), .driveEnable(driveEnable), .rdByteReady(rdByteReady), .rdByte(rdByte),
    .wrBit(wrBit), .wrBitStrobe(wrBitStrobe), .wrActive(wrActive));
  initial clk8 = 1'b0;
  always #5 clk8 = ~clk8;
  always @(posedge clk8) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk8);
    #1;
  endtask
  // one-cycle CPU access; expected read data is queued at drive time and popped at the sample point
  task automatic acc(input logic [3:0] a, input logic rw, input logic [7:0] d, input logic [7:0] exp, input string tag);
    selectIWM = 1'b1;
    _cpuLDS = 1'b0;
    cpuAddrRegHi = a;
    _cpuRW = rw;
    dataIn = d;
    exp_q.push_back(exp);
    @(negedge clk8);
    chk(tag, 32'(dataOut), 32'(exp_q.pop_front()));
    @(posedge clk8);
    #1;
    selectIWM = 1'b0;
    _cpuLDS = 1'b1;
    _cpuRW = 1'b1;
  endtask
  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask
  always @(negedge clk8) if (wrBitStrobe) begin
    strobes++;
    if (exp_bits.size() == 0) chk("stray_strobe", 32'(wrBitStrobe), 32'd0);
    else begin
      chk("wr_bit", 32'(wrBit), 32'(exp_bits.pop_front()));
      if (last_strobe >= 0) chk("bit_spacing", cyc - last_strobe, 16);
      else first_strobe = cyc;
      last_strobe = cyc;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; selectIWM = 1'b0; _cpuLDS = 1'b1; _cpuRW = 1'b1; cpuAddrRegHi = '0;
    dataIn = '0; driveBank = '0; rdByteReady = '0; rdByte = '0;
    tick(3);
    reset = 1'b0;
    chk("rst_dataout", 32'(dataOut), 32'hFF);
    chk("rst_ca", 32'(ca), 0);
    chk("rst_lstrb", 32'(lstrb), 0);
    chk("rst_enable", 32'(driveEnable), 0);
    chk("rst_wractive", 32'(wrActive), 0);
    chk("rst_strobe", 32'(wrBitStrobe), 0);
    chk("rst_wrbit", 32'(wrBit), 0);
    acc(4'b1111, 1, 0, 8'hC0, "hs_reset");
    acc(4'b1110, 0, 0, 8'hFF, "write_ff");
    acc(4'b0001, 0, 0, 8'hFF, "ca0_set");
    acc(4'b0101, 0, 0, 8'hFF, "ca2_set");
    acc(4'b0111, 0, 0, 8'hFF, "lstrb_set");
    chk("ca_101", 32'(ca), 32'b101);
    chk("lstrb_1", 32'(lstrb), 1);
    acc(4'b0110, 0, 0, 8'hFF, "lstrb_clr");
    chk("lstrb_0", 32'(lstrb), 0);
    // drive 2 = {driveBank=1, selExt=0}; drive 0 byte must be ignored
    driveBank = 2'd1;
    acc(4'b1001, 0, 0, 8'hFF, "mtr_on");
    chk("enable_drive2", 32'(driveEnable), 32'b0100);
    rdByte = 32'h00D5_0077;
    rdByteReady = 4'b0001;
    tick(1);
    rdByteReady = '0;
    acc(4'b1100, 1, 0, 8'h00, "ignored_drive");
    rdByteReady = 4'b0100;
    tick(1);
    rdByteReady = '0;
    acc(4'b1100, 1, 0, 8'hD5, "latch_data");
    tick(14);
    acc(4'b1100, 1, 0, 8'hD5, "latch_before_clr");
    acc(4'b1100, 1, 0, 8'h00, "latch_cleared");
    acc(4'b1101, 1, 0, 8'hA0, "status_enabled");
    acc(4'b1000, 0, 0, 8'hFF, "mtr_off");
    tick(49);
    chk("motor_hold", 32'(driveEnable), 32'b0100);
    tick(1);
    chk("motor_off", 32'(driveEnable), 0);
    acc(4'b1001, 0, 0, 8'hFF, "mtr_on2");
    acc(4'b1000, 0, 0, 8'hFF, "mtr_off2");
    tick(19);
    acc(4'b1001, 0, 0, 8'hFF, "mtr_on_cancel");
    tick(40);
    chk("motor_cancel", 32'(driveEnable), 32'b0100);
    acc(4'b1000, 0, 0, 8'hFF, "mtr_off3");
    tick(50);
    chk("motor_off3", 32'(driveEnable), 0);
    rdByte = '0;
    acc(4'b1111, 0, 8'h1F, 8'hFF, "mode_wr7");
    acc(4'b1101, 0, 8'h1F, 8'hFF, "mode_wr6");
    acc(4'b1110, 1, 0, 8'h1F, "status_mode");
    rdByte = 32'h00D5_0000;
    acc(4'b1001, 0, 0, 8'hFF, "mtr_on_l1");
    rdByteReady = 4'b0100;
    tick(1);
    rdByteReady = '0;
    acc(4'b1100, 1, 0, 8'hD5, "latch_l1");
    tick(100);
    acc(4'b1100, 1, 0, 8'hD5, "latch_hold_l1");
    acc(4'b1101, 0, 0, 8'hFF, "q6_set");
    push_byte(8'hA5);
    acc(4'b1111, 0, 8'hA5, 8'hFF, "buf_a5");
    t0 = cyc;
    push_byte(8'h3C);
    acc(4'b1111, 0, 8'h3C, 8'hFF, "buf_3c");
    chk("wr_active", 32'(wrActive), 1);
    for (int i = 0; i < 400 && strobes < 16; i++) tick(1);
    chk("strobe_count", strobes, 16);
    chk("first_strobe_latency", first_strobe - t0, 17);
    tick(2);
    chk("underrun_inactive", 32'(wrActive), 0);
    acc(4'b1100, 1, 0, 8'h80, "hs_underrun");
    acc(4'b1110, 0, 0, 8'hFF, "q7_clr");
    tick(1);
    acc(4'b1111, 1, 0, 8'hC0, "hs_cleared");
    acc(4'b1000, 0, 0, 8'hFF, "mtr_off_m1");
    chk("motor_off_immediate", 32'(driveEnable), 0);
    acc(4'b1001, 0, 0, 8'hFF, "mtr_on_rst");
    acc(4'b1101, 0, 8'hFF, 8'hFF, "buf_ff");
    tick(5);
    chk("pre_reset_active", 32'(wrActive), 1);
    s0 = strobes;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("reset_wractive", 32'(wrActive), 0);
    chk("reset_enable", 32'(driveEnable), 0);
    chk("reset_strobe", 32'(wrBitStrobe), 0);
    tick(60);
    chk("no_strobe_after_reset", strobes, s0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/iwm_multi.md
IWM_MULTI -- requirements
Module: iwm_multi

Interface
REQ-001 SHALL provide parameter NUM_DRIVES, default 2, number of drive channels (2, 4 or 8).
REQ-002 SHALL provide parameter BITCELL_CLKS, default 16, clk8 cycles per write bit cell (2 us at 8 MHz).
REQ-003 SHALL provide parameter LATCH_CLR_CLKS, default 14, clk8 cycles from end of a valid data read to read-latch clear in L=0 mode.
REQ-004 SHALL provide parameter MOTOR_OFF_CLKS, default 8000000, clk8 cycles an enable is held after mtrOff when M=0.
REQ-005 SHALL have ports; one clock; reset is synchronous and active-high:
- clk8  in  1  system clock
- reset  in  1  synchronous, active-high
- selectIWM  in  1  IWM address decode
- _cpuRW  in  1  1=read, 0=write
- _cpuLDS  in  1  low data strobe, active low
- cpuAddrRegHi  in  4  register index: [3:1] register, [0] value
- dataIn  in  8  CPU write data
- dataOut  out  8  CPU read data
- driveBank  in  2  upper drive-index bits
- ca  out  3  {ca2,ca1,ca0} to drives
- lstrb  out  1  phase-3 strobe
- driveEnable  out  NUM_DRIVES  per-drive enable, active high
- rdByteReady  in  NUM_DRIVES  per-drive new-byte pulse
- rdByte  in  8*NUM_DRIVES  per-drive byte; bit 7 of each is also that drive's sense
- wrBit  out  1  serial write data bit, MSB first
- wrBitStrobe  out  1  one-cycle pulse per bit cell
- wrActive  out  1  write serializer running

Function
REQ-006 An access SHALL be selectIWM=1 and _cpuLDS=0; on every access cycle, register cpuAddrRegHi[3:1] SHALL take value cpuAddrRegHi[0] at the next clk8 edge: 0 ca0, 1 ca1, 2 ca2, 3 lstrb, 4 enable of selected drive, 5 selExt, 6 q6, 7 q7.
REQ-007 Selected drive index SHALL be {driveBank, selExt}, truncated to log2(NUM_DRIVES) bits.
REQ-008 dataOut SHALL be combinational, 8'hFF when not a read access; on a read access it SHALL decode {q7,q6} after applying the current access's register update.
- 00: read latch.
- 01: {sense[idx], 0, any driveEnable, mode[4:0]}.
- 10: {~bufFull, ~underrun, 6'b0}.
- 11: 8'h00.
REQ-009 A write access with {q7,q6}=11 SHALL load mode[4:0]=dataIn[4:0] when all driveEnable=0; otherwise it SHALL load the write buffer and set bufFull.
REQ-010 Mode bits SHALL be [4]S [3]C [2]M [1]H [0]L; only M and L change behaviour.
REQ-011 Motor: mtrOn SHALL assert driveEnable[idx] the next cycle.
- mtrOff with M=1 SHALL deassert it the next cycle.
- mtrOff with M=0 SHALL start a per-drive MOTOR_OFF_CLKS countdown, deasserting at 0.
- A mtrOn during the countdown SHALL cancel it.
REQ-012 Read latch: rdByteReady[idx]=1 SHALL load rdByte[idx] into the latch next cycle; non-selected drives SHALL be ignored.
REQ-013 In L=0, the falling edge of a read access with latch[7]=1 SHALL start a LATCH_CLR_CLKS countdown; at expiry the latch SHALL clear to 0.
- An arriving byte SHALL win over a simultaneous clear.
- In L=1 the latch SHALL hold until the next byte.
REQ-014 Serializer states SHALL be IDLE, SHIFT, UNDERRUN; wrActive=1 in SHIFT.
REQ-015 IDLE->SHIFT when q7=1, driveEnable[idx]=1 and bufFull=1: the buffer loads the shift register, bufFull clears, and the bit counter is set to 8.
REQ-016 In SHIFT, every BITCELL_CLKS cycles the serializer SHALL output the MSB on wrBit, pulse wrBitStrobe for one cycle and shift left.
- After the 8th bit, if bufFull=1 it SHALL reload with no gap cell.
- Otherwise it SHALL go to UNDERRUN and set underrun.
REQ-017 From SHIFT or UNDERRUN, q7=0 or driveEnable[idx]=0 SHALL return to IDLE; underrun SHALL clear only on q7=0.
REQ-018 A buffer write while bufFull=1 SHALL overwrite the buffer, which is lost data, not an error.

Reset
REQ-019 On reset: ca=0, lstrb=0, selExt=0, q6=q7=0, mode=0, driveEnable=0, all motor countdowns cleared, latch=0, clear timer=0, bufFull=0, underrun=0, serializer IDLE, wrBit=0, wrBitStrobe=0, wrActive=0.
REQ-020 Reset mid-write SHALL abort the serializer immediately, with no further wrBitStrobe pulses.

Verification
REQ-021 Write access reg 7 val 1, reg 6 val 1, all enables 0, dataIn=8'h1F -> mode=5'h1F; status read ({q7,q6}=01) returns 8'h1F.
REQ-022 NUM_DRIVES=4, driveBank=1, selExt=0, mtrOn, rdByteReady[2] with rdByte[2]=8'hD5, L=0 -> data read returns 8'hD5; 14 cycles after the read ends the latch returns 8'h00.
REQ-023 Same as REQ-022 with L=1 -> latch still 8'hD5 after 100 cycles.
REQ-024 Drive enabled, q7=q6=1, write 8'hA5 then 8'h3C before the first byte ends -> 16 strobes, wrBit sequence 10100101 00111100 at 16-cycle spacing, then UNDERRUN; handshake read 8'h80; q7=0 clears underrun -> 8'hC0.
REQ-025 M=0, mtrOff -> driveEnable stays 1 for MOTOR_OFF_CLKS cycles (bench overrides the parameter to 50), then 0; mtrOn at cycle 20 keeps it 1.
